// File: rtl/prgrom_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prgrom_pkg
//  Description : Shared constants and types for the program-ROM responder.
//                - PRGROM_ADDR_W   : default word-address width
//                - PRGROM_NOP_WORD : instruction returned while the ROM is busy
//                - BYTES_PER_WORD  : loader bytes assembled into one word
//                - state_e         : responder state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package prgrom_pkg;

    localparam int          PRGROM_ADDR_W   = 14;
    localparam logic [31:0] PRGROM_NOP_WORD = 32'h0000_0000;
    localparam int          BYTES_PER_WORD  = 4;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : prgrom_pkg
`default_nettype wire

// File: rtl/byte_asm32.sv
`default_nettype none
// ============================================================================
//  Module      : byte_asm32
//  Description : Assembles a big-endian 32-bit word from a stream of bytes.
//                The first accepted byte lands in [31:24], the fourth in
//                [7:0]. The completed word is presented combinationally in
//                the same cycle as the fourth byte so the caller can write
//                it on that clock edge.
//  Ports       : clock      - system clock (posedge)
//                reset      - synchronous active-low reset
//                clear      - discard any partially assembled word
//                in_byte    - incoming byte
//                in_valid   - byte transfer this cycle (valid && ready)
//                word       - assembled word (meaningful with word_valid)
//                word_valid - one-cycle pulse on the fourth byte
//                byte_cnt   - bytes already held for the current word
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_asm32
    import prgrom_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic [31:0] word,
    output logic        word_valid,
    output logic [1:0]  byte_cnt
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    // Only the first three bytes need storage; the fourth is taken straight
    // from the input when the word completes.
    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q,   cnt_d;

    always_comb begin
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        word_valid = 1'b0;
        word       = {shift_q, in_byte};
        if (clear) begin
            cnt_d = 2'd0;
        end else if (in_valid) begin
            shift_d = {shift_q[15:0], in_byte};
            if (cnt_q == LAST_LANE) begin
                word_valid = 1'b1;
                cnt_d      = 2'd0;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign byte_cnt = cnt_q;

endmodule : byte_asm32
`default_nettype wire

// File: rtl/prgrom_resp.sv
`default_nettype none
// ============================================================================
//  Module      : prgrom_resp
//  Description : Program-ROM responder for the instruction-fetch interface.
//                Returns mem[rom_adr_i] one cycle after the address is
//                sampled. A boot-load path writes a byte stream from the
//                serial loader into the array; while it runs rom_busy is
//                high and Jpadr returns NOP_WORD.
//  Optional    : PRGROM_CSUM_EN - when defined, ld_csum carries the
//                modulo-2^32 sum of the words written by the current load;
//                otherwise ld_csum is tied to zero.
//  Ports       : clock     - system clock (posedge)
//                reset     - synchronous active-low reset
//                rom_adr_i - fetch word address
//                Jpadr     - registered instruction word
//                rom_busy  - load in progress, fetch must hold its PC
//                ld_start  - pulse that begins a download
//                ld_len    - words to load, latched on ld_start
//                ld_byte   - loader byte
//                ld_valid  - ld_byte is valid
//                ld_ready  - responder accepts a byte
//                ld_done   - one-cycle pulse when the download completes
//                ld_err    - sticky: ld_start seen while loading
//                ld_csum   - checksum of the current load
//  Revision    : 1.0 - initial release
// ============================================================================
module prgrom_resp
    import prgrom_pkg::*;
#(
    parameter int          ADDR_W   = PRGROM_ADDR_W,
    parameter logic [31:0] NOP_WORD = PRGROM_NOP_WORD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rom_adr_i,
    output logic [31:0]       Jpadr,
    output logic              rom_busy,
    input  logic              ld_start,
    input  logic [ADDR_W:0]   ld_len,
    input  logic [7:0]        ld_byte,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              ld_done,
    output logic              ld_err,
    output logic [31:0]       ld_csum
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LEN_MAX   = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]      LAST_LANE = 2'(BYTES_PER_WORD - 1);

    // ------------------------------------------------------------------------
    // State and control registers
    // ------------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [ADDR_W:0] len_q,   len_d;
    // One bit wider than the address so a full-depth load can terminate.
    logic [ADDR_W:0] wcnt_q,  wcnt_d;
    logic            err_q,   err_d;
    logic            done_q,  done_d;
    // Selects the array read data onto Jpadr; cleared whenever the previous
    // cycle was not a RUN cycle so that Jpadr shows NOP_WORD while busy.
    logic            sel_q,   sel_d;

    logic [31:0]     rd_data_q;
    logic [31:0]     mem [DEPTH];

    logic            start_acc;
    logic            byte_acc;
    logic            last_byte;
    logic            mem_we;
    logic [ADDR_W:0] len_clamped;
    logic [ADDR_W:0] wcnt_inc;

    logic [31:0]     asm_word;
    logic            asm_word_valid;
    logic [1:0]      asm_byte_cnt;
    logic            asm_clear;

    assign ld_ready    = (state_q == LOAD);
    assign rom_busy    = (state_q != RUN);
    assign ld_done     = done_q;
    assign ld_err      = err_q;
    assign Jpadr       = sel_q ? rd_data_q : NOP_WORD;

    assign start_acc   = (state_q == RUN) && ld_start;
    assign byte_acc    = ld_valid && ld_ready;
    assign len_clamped = (ld_len > LEN_MAX) ? LEN_MAX : ld_len;
    assign wcnt_inc    = wcnt_q + 1'b1;
    assign asm_clear   = (state_q != LOAD);
    // Same event as asm_word_valid, expressed from the lane count so the
    // completion decision does not depend on the assembled data path.
    assign last_byte   = byte_acc && (asm_byte_cnt == LAST_LANE);
    // A reset coinciding with the fourth byte discards that word too.
    assign mem_we      = asm_word_valid && reset;

    // ------------------------------------------------------------------------
    // Byte assembler
    // ------------------------------------------------------------------------
    byte_asm32 u_byte_asm32 (
        .clock      (clock),
        .reset      (reset),
        .clear      (asm_clear),
        .in_byte    (ld_byte),
        .in_valid   (byte_acc),
        .word       (asm_word),
        .word_valid (asm_word_valid),
        .byte_cnt   (asm_byte_cnt)
    );

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        done_d  = 1'b0;
        sel_d   = 1'b0;
        case (state_q)
            RUN: begin
                sel_d = 1'b1;
                if (ld_start) begin
                    err_d  = 1'b0;
                    wcnt_d = '0;
                    len_d  = len_clamped;
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (ld_start) begin
                    err_d = 1'b1;
                end
                if (last_byte) begin
                    wcnt_d = wcnt_inc;
                    if (wcnt_inc == len_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= RUN;
            len_q   <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            done_q  <= done_d;
            sel_q   <= sel_d;
        end
    end

    // ------------------------------------------------------------------------
    // Instruction array: single write port (LOAD only), registered read.
    // No reset so the array maps onto block RAM and survives a reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[wcnt_q[ADDR_W-1:0]] <= asm_word;
        end
        rd_data_q <= mem[rom_adr_i];
    end

    // ------------------------------------------------------------------------
    // Optional load checksum
    // ------------------------------------------------------------------------
`ifdef PRGROM_CSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_acc) begin
            csum_d = '0;
        end else if (mem_we) begin
            csum_d = csum_q + asm_word;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign ld_csum = csum_q;
`else
    assign ld_csum = '0;
`endif

endmodule : prgrom_resp
`default_nettype wire

// File: tb/tb_prgrom_resp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prgrom_resp
//  Description : Self-checking bench for prgrom_resp. A word-level model
//                (associative array of written words, running sum, error
//                flag) predicts every observed output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prgrom_resp;

    localparam int          AW  = 14;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] rom_adr_i = '0;
    logic [31:0]   Jpadr;
    logic          rom_busy;
    logic          ld_start = 1'b0;
    logic [AW:0]   ld_len = '0;
    logic [7:0]    ld_byte = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic          ld_done;
    logic          ld_err;
    logic [31:0]   ld_csum;

    always #5 clock = ~clock;

    prgrom_resp #(.ADDR_W(AW), .NOP_WORD(NOP)) dut (
        .clock     (clock),
        .reset     (reset),
        .rom_adr_i (rom_adr_i),
        .Jpadr     (Jpadr),
        .rom_busy  (rom_busy),
        .ld_start  (ld_start),
        .ld_len    (ld_len),
        .ld_byte   (ld_byte),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_done   (ld_done),
        .ld_err    (ld_err),
        .ld_csum   (ld_csum)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [int];
    logic [31:0] model_csum = '0;
    logic        model_err  = 1'b0;
    int          max_words  = 0;
    logic [31:0] wq [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_csum();
`ifdef PRGROM_CSUM_EN
        return model_csum;
`else
        return 32'h0;
`endif
    endfunction

    task automatic do_reset();
        reset    = 1'b0;
        ld_start = 1'b0;
        ld_valid = 1'b0;
        @(negedge clock);
        reset      = 1'b1;
        model_err  = 1'b0;
        model_csum = '0;
        check_eq("rst_jpadr", Jpadr, NOP);
        check_eq("rst_busy",  32'(rom_busy), 32'd0);
        check_eq("rst_ready", 32'(ld_ready), 32'd0);
        check_eq("rst_done",  32'(ld_done),  32'd0);
        check_eq("rst_err",   32'(ld_err),   32'd0);
        check_eq("rst_csum",  ld_csum, 32'h0);
    endtask

    // Outputs expected on every cycle spent in the loading state.
    task automatic check_loading(input int cyc);
        check_eq("ld_busy",  32'(rom_busy), 32'd1);
        check_eq("ld_ready", 32'(ld_ready), 32'd1);
        check_eq("ld_ndone", 32'(ld_done),  32'd0);
        if (cyc > 0) check_eq("ld_nop", Jpadr, NOP);
    endtask

    // Download the words in wq. gap < 0 means a random 0..2 cycle gap before
    // each byte. poke >= 0 pulses ld_start alongside that byte index.
    // stop_after >= 0 aborts with a reset after that many bytes.
    task automatic do_load(input int gap, input int poke, input int stop_after);
        int len;
        int cyc;
        int g;
        len      = wq.size();
        ld_start = 1'b1;
        ld_len   = (AW + 1)'(len);
        @(negedge clock);
        ld_start   = 1'b0;
        ld_len     = (AW + 1)'($urandom);
        model_err  = 1'b0;
        model_csum = '0;
        if (len == 0) begin
            check_eq("z_done", 32'(ld_done),  32'd1);
            check_eq("z_busy", 32'(rom_busy), 32'd0);
            check_eq("z_err",  32'(ld_err),   32'd0);
            @(negedge clock);
            check_eq("z_done2", 32'(ld_done),  32'd0);
            check_eq("z_busy2", 32'(rom_busy), 32'd0);
            return;
        end
        check_eq("ld_errclr", 32'(ld_err), 32'd0);
        cyc = 0;
        for (int bi = 0; bi < 4 * len; bi++) begin
            if (bi == stop_after) begin
                ld_valid = 1'b0;
                reset    = 1'b0;
                @(negedge clock);
                reset      = 1'b1;
                model_err  = 1'b0;
                model_csum = '0;
                check_eq("ab_busy",  32'(rom_busy), 32'd0);
                check_eq("ab_ready", 32'(ld_ready), 32'd0);
                check_eq("ab_done",  32'(ld_done),  32'd0);
                @(negedge clock);
                check_eq("ab_done2", 32'(ld_done),  32'd0);
                check_eq("ab_busy2", 32'(rom_busy), 32'd0);
                return;
            end
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) begin
                check_loading(cyc);
                cyc++;
                ld_valid = 1'b0;
                ld_byte  = 8'($urandom);
                @(negedge clock);
            end
            check_loading(cyc);
            cyc++;
            ld_valid = 1'b1;
            ld_byte  = wq[bi / 4][31 - 8 * (bi % 4) -: 8];
            if (bi == poke) begin
                ld_start  = 1'b1;
                model_err = 1'b1;
            end
            @(negedge clock);
            ld_start = 1'b0;
        end
        ld_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            model_mem[i] = wq[i];
            model_csum   = model_csum + wq[i];
        end
        if (len > max_words) max_words = len;
        check_eq("dn_done",  32'(ld_done),  32'd1);
        check_eq("dn_busy",  32'(rom_busy), 32'd1);
        check_eq("dn_ready", 32'(ld_ready), 32'd0);
        check_eq("dn_nop",   Jpadr, NOP);
        @(negedge clock);
        check_eq("run_done", 32'(ld_done),  32'd0);
        check_eq("run_busy", 32'(rom_busy), 32'd0);
        check_eq("run_nop",  Jpadr, NOP);
        check_eq("run_csum", ld_csum, exp_csum());
        check_eq("run_err",  32'(ld_err), 32'(model_err));
    endtask

    // Back-to-back reads, one address per cycle.
    task automatic read_addr(input int a);
        rom_adr_i = AW'(a);
        @(negedge clock);
        check_eq($sformatf("rd[%0d]", a), Jpadr, model_mem[a]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        do_reset();

        // Two-word load, no gaps, then consecutive reads.
        wq = '{32'h1234_5678, 32'h9ABC_DEF0};
        do_load(0, -1, -1);
        read_addr(0);
        read_addr(1);

        // Single word with a 3-cycle gap before every byte.
        wq = '{32'hA5C3_0F96};
        do_load(3, -1, -1);
        read_addr(0);
        read_addr(1);

        // Zero-length load.
        wq.delete();
        do_load(0, -1, -1);

        // ld_start during LOAD: sticky error, load unaffected.
        wq = '{32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h0102_0304};
        do_load(-1, 5, -1);
        for (int i = 0; i < 3; i++) begin
            rom_adr_i = AW'(i);
            @(negedge clock);
            check_eq("err_sticky", 32'(ld_err), 32'd1);
            check_eq($sformatf("rd_err[%0d]", i), Jpadr, model_mem[i]);
        end
        wq = '{32'h7777_8888};
        do_load(-1, -1, -1);

        // Reset after two of four bytes: abort, partial byte discarded.
        wq = '{32'hFFFF_FFFF};
        do_load(0, -1, 2);
        wq = '{32'hCAFE_BABE};
        do_load(0, -1, -1);
        read_addr(0);

        // Checksum of 1 + 2.
        wq = '{32'd1, 32'd2};
        do_load(-1, -1, -1);
        check_eq("csum3", ld_csum, exp_csum());

        // Randomized loads and reads.
        for (int t = 0; t < 8; t++) begin
            wq.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) wq.push_back($urandom);
            do_load(-1, -1, -1);
            for (int r = 0; r < 6; r++) read_addr(int'($urandom_range(0, max_words - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_prgrom_resp
`default_nettype wire

// File: doc/prgrom_resp.md
Name: prgrom_resp

Overview:
Program-ROM responder on the far side of the instruction-fetch interface. It answers the fetch unit's 14-bit word address with a 32-bit instruction word. It also contains a boot-load path that writes a byte stream from the serial loader into the ROM array. While loading is in progress it drives `rom_busy` high, and the fetch stage must hold its PC until `rom_busy` drops.

Parameters:
- ADDR_W, 14, word-address width; array depth = 2**ADDR_W.
- NOP_WORD, 32'h0000_0000, instruction returned while busy.

Ports:
- clock  in  1  system clock, posedge domain.
- reset  in  1  synchronous, active-low reset.
- rom_adr_i  in  ADDR_W  fetch word address (PC[15:2]).
- Jpadr  out  32  instruction to the fetch unit.
- rom_busy  out  1  high while loading; the fetch stage must not advance PC.
- ld_start  in  1  one-cycle pulse that begins a download.
- ld_len  in  ADDR_W+1  number of words to load; latched on ld_start.
- ld_byte  in  8  loader byte.
- ld_valid  in  1  ld_byte is valid.
- ld_ready  out  1  responder accepts a byte; a transfer occurs on ld_valid&&ld_ready.
- ld_done  out  1  one-cycle pulse when the download completes.
- ld_err  out  1  sticky error flag; cleared by reset or by an accepted ld_start.
- ld_csum  out  32  checksum, present only with the optional feature.

Behaviour:
- Reset (reset==0 at a posedge):
  - state=RUN.
  - Jpadr=NOP_WORD; rom_busy=0; ld_ready=0; ld_done=0; ld_err=0; ld_csum=0.
  - Byte counter=0; word address counter=0.
  - Array contents are not cleared.
- RUN state:
  - Synchronous read: Jpadr at posedge N+1 equals mem[rom_adr_i sampled at posedge N]. Latency is 1 cycle, matching the fetcher's negedge PC update.
  - ld_start=1: latch ld_len, clamped to 2**ADDR_W. If the clamped value is 0, pulse ld_done next cycle and stay in RUN. Otherwise go to LOAD.
- LOAD state:
  - rom_busy=1 and ld_ready=1.
  - Jpadr=NOP_WORD, registered, starting the cycle after entry.
  - Accepted bytes are assembled big-endian: the first byte goes to [31:24], the fourth to [7:0].
  - On the 4th accepted byte: write the word to mem[wcnt] in that same cycle, increment wcnt, and reset the byte counter.
  - When wcnt reaches the latched length, the write completes and the next state is DONE.
  - ld_start seen in LOAD is ignored and sets ld_err.
  - ld_valid=0 stalls the load indefinitely; there is no timeout.
- DONE state, one cycle:
  - ld_ready=0, rom_busy=1, ld_done=1.
  - Then return to RUN; rom_busy=0 from the next cycle.
  - The first valid read is issued in that RUN cycle.
- Reset asserted mid-LOAD: return to RUN immediately. Partially written words remain in the array; the byte in assembly is discarded; ld_done is not pulsed.
- Write/read same address: reads only happen in RUN and writes only happen in LOAD, so no collision arises.
- Address wrap: wcnt is ADDR_W+1 bits wide, so clamped length 2**ADDR_W terminates without aliasing.

Optional Feature:
- PRGROM_CSUM_EN defined:
  - ld_csum = modulo-2^32 sum of all words written in the current load.
  - Cleared on an accepted ld_start; updated in the same cycle as each array write.
  - Holds its value after DONE.
- Undefined: ld_csum is tied to 0 and no adder is built.

Decomposition:
- Package prgrom_pkg holds:
  - ADDR_W default.
  - NOP_WORD.
  - State enum {RUN, LOAD, DONE}.
  - Byte-lane constant (4 bytes per word).
- One sub-module, byte_asm32. Inputs: byte, valid&&ready, clear. Outputs: word, word_valid pulse, 2-bit counter.
- The array is an inferred block RAM in the top module.

Test Plan:
1. Reset then load, ld_len=2, bytes 12 34 56 78 9A BC DE F0 -> two writes: mem[0]=32'h12345678, mem[1]=32'h9ABCDEF0. ld_done pulses one cycle after the last byte; rom_busy then falls.
2. After test 1, rom_adr_i=0 then 1 on consecutive cycles -> Jpadr=12345678 one cycle after address 0, then 9ABCDEF0 one cycle after address 1.
3. ld_valid gaps, with a 3-cycle low between every byte during ld_len=1 -> the word is still assembled correctly; ld_ready stays 1; Jpadr=0 throughout LOAD.
4. ld_start with ld_len=0 -> ld_done pulses next cycle; rom_busy never rises.
5. ld_start pulsed mid-LOAD -> ld_err=1 and stays 1; the load continues unchanged. A later accepted ld_start clears ld_err.
6. reset=0 after 2 of 4 bytes -> RUN, rom_busy=0, no ld_done. With PRGROM_CSUM_EN, a load of 1, 2 gives ld_csum=3.
